// File: rtl/image_window_fetch_pkg.sv
// Shared constants and FSM state type for the image window fetch path.
// The loader uses the same image geometry defaults and word count.
package npu_pkg;
    localparam int IMG_W_DEF = 28;
    localparam int IMG_H_DEF = 28;
    localparam int PIX_W_DEF = 8;
    // Four pixels per 32-bit RAM word
    localparam int IMG_WORDS = IMG_W_DEF * IMG_H_DEF / 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        WAIT   = 3'd2,
        UNPACK = 3'd3,
        DRAIN  = 3'd4,
        DONE   = 3'd5
    } state_t;
endpackage

// File: rtl/image_window_fetch_if.sv
// 3x3 window stream from the fetch block to the conv engine.
// master: window producer (drives data/coords/valid, samples ready)
// slave : window consumer
interface image_window_fetch_if #(
    parameter int PIX_W = npu_pkg::PIX_W_DEF
);
    logic [9*PIX_W-1:0] win_data;
    logic [4:0]         win_row;
    logic [4:0]         win_col;
    logic               win_valid;
    logic               win_ready;

    modport master (output win_data, output win_row, output win_col,
                    output win_valid, input win_ready);
    modport slave  (input win_data, input win_row, input win_col,
                    input win_valid, output win_ready);
endinterface

// File: rtl/image_window_fetch_linebuf.sv
// Two IMG_W-deep shift line buffers plus the 3x3 register window.
// Ports: clk, reset_n (async, active-low), shift_i (consume one pixel),
//        pix_i (incoming raster pixel), win_o (top-left in the MSBs).
module window_linebuf #(
    parameter int IMG_W = npu_pkg::IMG_W_DEF,
    parameter int PIX_W = npu_pkg::PIX_W_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               shift_i,
    input  logic [PIX_W-1:0]   pix_i,
    output logic [9*PIX_W-1:0] win_o
);
    // lb1 delays the stream by one row, lb0 by a second row
    logic [PIX_W-1:0] lb0_q [IMG_W];
    logic [PIX_W-1:0] lb1_q [IMG_W];
    logic [PIX_W-1:0] win_q [9];

    // Shift line buffers and window on every consumed pixel
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < IMG_W; i++) begin
                lb0_q[i] <= '0;
                lb1_q[i] <= '0;
            end
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= '0;
            end
        end else if (shift_i) begin
            lb1_q[0] <= pix_i;
            lb0_q[0] <= lb1_q[IMG_W-1];
            for (int i = 1; i < IMG_W; i++) begin
                lb1_q[i] <= lb1_q[i-1];
                lb0_q[i] <= lb0_q[i-1];
            end
            // Each window row shifts left; the right column takes the
            // pixel two rows up, one row up, and the current pixel.
            win_q[0] <= win_q[1];
            win_q[1] <= win_q[2];
            win_q[2] <= lb0_q[IMG_W-1];
            win_q[3] <= win_q[4];
            win_q[4] <= win_q[5];
            win_q[5] <= lb1_q[IMG_W-1];
            win_q[6] <= win_q[7];
            win_q[7] <= win_q[8];
            win_q[8] <= pix_i;
        end
    end

    assign win_o = {win_q[0], win_q[1], win_q[2],
                    win_q[3], win_q[4], win_q[5],
                    win_q[6], win_q[7], win_q[8]};
endmodule

// File: rtl/image_window_fetch.sv
// Reads packed image words from four byte-lane RAMs, serializes them into
// a raster pixel stream and emits valid-only 3x3 windows over valid/ready.
// Ports: clk, reset_n (async active-low), start_i (pass start pulse),
//        img_addr_o/img_rden_o (shared RAM address / mux select),
//        rd0_i..rd3_i (RAM lanes 0..3), busy_o, done_o,
//        win (window stream, master side).
module image_window_fetch
    import npu_pkg::*;
#(
    parameter int IMG_W    = IMG_W_DEF,
    parameter int IMG_H    = IMG_H_DEF,
    parameter int ADDR_W   = 14,
    parameter int IMG_BASE = 0,
    parameter int PIX_W    = PIX_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start_i,
    output logic [ADDR_W-1:0] img_addr_o,
    output logic              img_rden_o,
    input  logic [PIX_W-1:0]  rd0_i,
    input  logic [PIX_W-1:0]  rd1_i,
    input  logic [PIX_W-1:0]  rd2_i,
    input  logic [PIX_W-1:0]  rd3_i,
    output logic              busy_o,
    output logic              done_o,
    image_window_fetch_if.master win
);
    localparam logic [4:0] COL_LAST = 5'(IMG_W - 1);
    localparam logic [4:0] ROW_LAST = 5'(IMG_H - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [4*PIX_W-1:0]  word_q, word_d;
    logic [1:0]          lane_q, lane_d;
    logic [4:0]          row_q, row_d, col_q, col_d;
    logic                wv_q, wv_d;
    logic [4:0]          wr_q, wr_d, wc_q, wc_d;
    logic                stall_s, shift_s;
    logic [PIX_W-1:0]    pix_s;

    assign stall_s = wv_q & ~win.win_ready;

    // Lane 0 sits in the MSBs of the captured word
    always_comb begin
        pix_s = '0;
        case (lane_q)
            2'd0:    pix_s = word_q[4*PIX_W-1:3*PIX_W];
            2'd1:    pix_s = word_q[3*PIX_W-1:2*PIX_W];
            2'd2:    pix_s = word_q[2*PIX_W-1:PIX_W];
            2'd3:    pix_s = word_q[PIX_W-1:0];
            default: pix_s = '0;
        endcase
    end

    // Next-state, address, raster position and window emit logic
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        word_d  = word_q;
        lane_d  = lane_q;
        row_d   = row_q;
        col_d   = col_q;
        wv_d    = wv_q & ~win.win_ready;
        wr_d    = wr_q;
        wc_d    = wc_q;
        shift_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = FETCH;
                    addr_d  = ADDR_W'(IMG_BASE);
                    lane_d  = 2'd0;
                    row_d   = 5'd0;
                    col_d   = 5'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH: state_d = WAIT;
            WAIT: begin
                word_d  = {rd0_i, rd1_i, rd2_i, rd3_i};
                state_d = UNPACK;
            end
            UNPACK: begin
                if (!stall_s) begin
                    shift_s = 1'b1;
                    lane_d  = lane_q + 2'd1;
                    if (col_q == COL_LAST) begin
                        col_d = 5'd0;
                        row_d = row_q + 5'd1;
                    end else begin
                        col_d = col_q + 5'd1;
                    end
                    // Only windows fully inside the image are emitted
                    if ((row_q >= 5'd2) && (col_q >= 5'd2)) begin
                        wv_d = 1'b1;
                        wr_d = row_q - 5'd2;
                        wc_d = col_q - 5'd2;
                    end else begin
                        wv_d = wv_q & ~win.win_ready;
                    end
                    if (lane_q == 2'd3) begin
                        if ((row_q == ROW_LAST) && (col_q == COL_LAST)) begin
                            state_d = DRAIN;
                        end else begin
                            addr_d  = addr_q + ADDR_W'(1'b1);
                            state_d = FETCH;
                        end
                    end else begin
                        state_d = UNPACK;
                    end
                end else begin
                    state_d = UNPACK;
                end
            end
            DRAIN: begin
                if (!wv_q || win.win_ready) begin
                    state_d = DONE;
                end else begin
                    state_d = DRAIN;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            word_q  <= '0;
            lane_q  <= 2'd0;
            row_q   <= 5'd0;
            col_q   <= 5'd0;
            wv_q    <= 1'b0;
            wr_q    <= 5'd0;
            wc_q    <= 5'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            lane_q  <= lane_d;
            row_q   <= row_d;
            col_q   <= col_d;
            wv_q    <= wv_d;
            wr_q    <= wr_d;
            wc_q    <= wc_d;
        end
    end

    window_linebuf #(.IMG_W(IMG_W), .PIX_W(PIX_W)) u_linebuf (
        .clk     (clk),
        .reset_n (reset_n),
        .shift_i (shift_s),
        .pix_i   (pix_s),
        .win_o   (win.win_data)
    );

    assign img_addr_o    = addr_q;
    assign img_rden_o    = (state_q == FETCH) || (state_q == WAIT);
    assign busy_o        = (state_q != IDLE);
    assign done_o        = (state_q == DONE);
    assign win.win_valid = wv_q;
    assign win.win_row   = wr_q;
    assign win.win_col   = wc_q;
endmodule

// File: tb/tb_image_window_fetch.sv
module tb_image_window_fetch;
    localparam int W = 28;
    localparam int H = 28;
    localparam int NWORDS = 196;
    localparam int NWIN = 676;
    localparam int LIMIT = 20000;

    typedef struct packed {
        logic [71:0] d;
        logic [4:0]  r;
        logic [4:0]  c;
    } win_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [13:0] img_addr;
    logic        img_rden;
    logic [7:0]  rd0, rd1, rd2, rd3;
    logic        busy, done;

    image_window_fetch_if win_if ();

    image_window_fetch dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start_i    (start),
        .img_addr_o (img_addr),
        .img_rden_o (img_rden),
        .rd0_i      (rd0),
        .rd1_i      (rd1),
        .rd2_i      (rd2),
        .rd3_i      (rd3),
        .busy_o     (busy),
        .done_o     (done),
        .win        (win_if)
    );

    always #5 clk = ~clk;

    logic [7:0]  pix [W*H];
    win_t        exp_q [$];
    logic [71:0] got_d [$];
    int total = 0, bad = 0;
    int windows_seen = 0, done_cnt = 0, exp_addr = 0, rden_cycles = 0, stall_cycles = 0;
    bit mon_en = 1'b0;
    int ready_mode = 0;
    int hold_cnt = 0;

    // Synchronous image RAM model: address sampled, data available next cycle
    always @(posedge clk) begin
        if (int'(img_addr) < NWORDS) begin
            rd0 <= pix[4*int'(img_addr)+0];
            rd1 <= pix[4*int'(img_addr)+1];
            rd2 <= pix[4*int'(img_addr)+2];
            rd3 <= pix[4*int'(img_addr)+3];
        end else begin
            rd0 <= 8'hEE; rd1 <= 8'hEE; rd2 <= 8'hEE; rd3 <= 8'hEE;
        end
    end

    // win_ready driver: always ready, or a 10-cycle hold at window 5 then random
    initial begin
        win_if.win_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (ready_mode == 0) begin
                win_if.win_ready = 1'b1;
            end else if (windows_seen >= 5 && hold_cnt < 10) begin
                win_if.win_ready = 1'b0;
                hold_cnt++;
            end else if (hold_cnt >= 10) begin
                win_if.win_ready = 1'($urandom_range(0, 1));
            end else begin
                win_if.win_ready = 1'b1;
            end
        end
    end

    // Monitor: scoreboard pops, stall stability, done/busy, address trace
    initial begin
        bit stall_prev, done_prev, rden_prev;
        logic [71:0] snap_d;
        logic [4:0] snap_r, snap_c;
        win_t e;
        stall_prev = 0; done_prev = 0; rden_prev = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                stall_prev = 0; done_prev = 0; rden_prev = 0;
            end else begin
                if (stall_prev) begin
                    total++;
                    if (win_if.win_valid !== 1'b1 || win_if.win_data !== snap_d ||
                        win_if.win_row !== snap_r || win_if.win_col !== snap_c) begin
                        bad++;
                        $display("FAIL stall_stable: got v=%b %h (%0d,%0d) want v=1 %h (%0d,%0d)",
                                 win_if.win_valid, win_if.win_data, win_if.win_row, win_if.win_col,
                                 snap_d, snap_r, snap_c);
                    end
                end
                stall_prev = win_if.win_valid && !win_if.win_ready;
                if (stall_prev) stall_cycles++;
                snap_d = win_if.win_data; snap_r = win_if.win_row; snap_c = win_if.win_col;
                if (win_if.win_valid && win_if.win_ready) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL extra_window: got (%0d,%0d) %h want none",
                                 win_if.win_row, win_if.win_col, win_if.win_data);
                    end else begin
                        e = exp_q.pop_front();
                        if ({win_if.win_data, win_if.win_row, win_if.win_col} !== e) begin
                            bad++;
                            $display("FAIL window: got (%0d,%0d) %h want (%0d,%0d) %h",
                                     win_if.win_row, win_if.win_col, win_if.win_data, e.r, e.c, e.d);
                        end
                    end
                    got_d.push_back(win_if.win_data);
                    windows_seen++;
                end
                if (done_prev) begin
                    total++;
                    if (busy !== 1'b0) begin
                        bad++;
                        $display("FAIL busy_fall: got busy=%b want 0", busy);
                    end
                end
                if (done) begin
                    done_cnt++;
                    total++;
                    if (busy !== 1'b1) begin
                        bad++;
                        $display("FAIL busy_at_done: got busy=%b want 1", busy);
                    end
                end
                done_prev = done;
                if (img_rden) rden_cycles++;
                if (img_rden && !rden_prev) begin
                    total++;
                    if (int'(img_addr) !== exp_addr) begin
                        bad++;
                        $display("FAIL addr_trace: got %0d want %0d", img_addr, exp_addr);
                    end
                    exp_addr++;
                end
                rden_prev = img_rden;
            end
        end
    end

    task automatic fill_ramp();
        for (int p = 0; p < W*H; p++) pix[p] = 8'(p);
    endtask

    // Expected window stream: every fully-inside window in raster order
    task automatic load_model();
        win_t e;
        exp_q.delete();
        got_d.delete();
        for (int r = 0; r < H-2; r++) begin
            for (int c = 0; c < W-2; c++) begin
                e.d = {pix[r*W+c], pix[r*W+c+1], pix[r*W+c+2],
                       pix[(r+1)*W+c], pix[(r+1)*W+c+1], pix[(r+1)*W+c+2],
                       pix[(r+2)*W+c], pix[(r+2)*W+c+1], pix[(r+2)*W+c+2]};
                e.r = 5'(r);
                e.c = 5'(c);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic start_pass();
        load_model();
        windows_seen = 0; done_cnt = 0; exp_addr = 0; rden_cycles = 0;
        stall_cycles = 0; hold_cnt = 0;
        mon_en = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(output bit timed_out, output int cycles);
        timed_out = 1'b1;
        cycles = 0;
        for (int n = 0; n < LIMIT; n++) begin
            @(posedge clk); #1;
            cycles++;
            if (done) begin
                timed_out = 1'b0;
                break;
            end
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({img_addr, img_rden, busy, done, win_if.win_valid} !== 18'd0) begin
            bad++;
            $display("FAIL reset_ctrl: got addr=%0d rden=%b busy=%b done=%b valid=%b want all 0",
                     img_addr, img_rden, busy, done, win_if.win_valid);
        end
        total++;
        if ({win_if.win_data, win_if.win_row, win_if.win_col} !== 82'd0) begin
            bad++;
            $display("FAIL reset_win: got %h (%0d,%0d) want 0", win_if.win_data,
                     win_if.win_row, win_if.win_col);
        end
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic check_pass_end(input string tag, input bit to);
        total++;
        if (to) begin bad++; $display("FAIL %s_timeout: got no done want done", tag); end
        total++;
        if (windows_seen !== NWIN) begin
            bad++; $display("FAIL %s_count: got %0d want %0d", tag, windows_seen, NWIN);
        end
        total++;
        if (exp_q.size() !== 0) begin
            bad++; $display("FAIL %s_missing: got %0d left want 0", tag, exp_q.size());
        end
        total++;
        if (done_cnt !== 1) begin
            bad++; $display("FAIL %s_done: got %0d pulses want 1", tag, done_cnt);
        end
        total++;
        if (exp_addr !== NWORDS || rden_cycles !== 2*NWORDS) begin
            bad++; $display("FAIL %s_reads: got %0d words %0d rden want %0d %0d", tag,
                            exp_addr, rden_cycles, NWORDS, 2*NWORDS);
        end
    endtask

    task automatic test_ramp();
        bit to; int cyc;
        fill_ramp();
        ready_mode = 0;
        start_pass();
        wait_done(to, cyc);
        check_pass_end("ramp", to);
        total++;
        if (got_d.size() < 1 || got_d[0] !== 72'h00_01_02_1C_1D_1E_38_39_3A) begin
            bad++; $display("FAIL ramp_first: got %h want 0001021c1d1e38393a",
                            got_d.size() > 0 ? got_d[0] : 72'd0);
        end
        total++;
        if (got_d.size() < NWIN || got_d[NWIN-1] !== 72'hD5_D6_D7_F1_F2_F3_0D_0E_0F) begin
            bad++; $display("FAIL ramp_last: got %h want d5d6d7f1f2f30d0e0f",
                            got_d.size() >= NWIN ? got_d[NWIN-1] : 72'd0);
        end
        total++;
        if (cyc < 1176 || cyc > 1190) begin
            bad++; $display("FAIL ramp_cycles: got %0d want 1176..1190", cyc);
        end
    endtask

    task automatic test_byte_order();
        bit to; int cyc;
        fill_ramp();
        pix[0] = 8'h0A; pix[1] = 8'h0B; pix[2] = 8'h0C; pix[3] = 8'h0D;
        ready_mode = 0;
        start_pass();
        wait_done(to, cyc);
        check_pass_end("bytes", to);
        total++;
        if (got_d.size() < 2 || got_d[0][71:48] !== 24'h0A0B0C || got_d[1][71:48] !== 24'h0B0C0D) begin
            bad++; $display("FAIL byte_order: got %h %h want top rows 0a0b0c 0b0c0d",
                            got_d.size() > 0 ? got_d[0] : 72'd0, got_d.size() > 1 ? got_d[1] : 72'd0);
        end
    endtask

    task automatic test_backpressure();
        bit to; int cyc;
        fill_ramp();
        ready_mode = 1;
        start_pass();
        wait_done(to, cyc);
        ready_mode = 0;
        check_pass_end("bp", to);
        total++;
        if (stall_cycles < 10) begin
            bad++; $display("FAIL bp_stalled: got %0d stall cycles want >=10", stall_cycles);
        end
    endtask

    task automatic test_reset_mid();
        bit to; int cyc;
        fill_ramp();
        ready_mode = 0;
        start_pass();
        to = 1'b1;
        for (int n = 0; n < LIMIT; n++) begin
            @(posedge clk); #1;
            if (windows_seen >= 300) begin to = 1'b0; break; end
        end
        total++;
        if (to) begin bad++; $display("FAIL rmid_reach: got %0d windows want 300", windows_seen); end
        mon_en = 1'b0;
        reset_n = 1'b0;
        #1;
        total++;
        if ({img_addr, img_rden, busy, done, win_if.win_valid, win_if.win_row, win_if.win_col} !== 28'd0
            || win_if.win_data !== 72'd0) begin
            bad++;
            $display("FAIL rmid_outputs: got addr=%0d rden=%b busy=%b done=%b v=%b data=%h want all 0",
                     img_addr, img_rden, busy, done, win_if.win_valid, win_if.win_data);
        end
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clk);
        start_pass();
        wait_done(to, cyc);
        check_pass_end("rmid", to);
    endtask

    task automatic test_start_ignored();
        bit to;
        fill_ramp();
        ready_mode = 0;
        start_pass();
        repeat (100) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        to = 1'b1;
        for (int n = 0; n < LIMIT; n++) begin
            @(posedge clk); #1;
            if (done) begin to = 1'b0; break; end
        end
        // start lands in the DONE cycle
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check_pass_end("start_ign", to);
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL start_ign_busy: got busy=%b want 0", busy);
        end
    endtask

    initial begin
        for (int p = 0; p < W*H; p++) pix[p] = 8'd0;
        test_reset();
        test_ramp();
        test_byte_order();
        test_backpressure();
        test_reset_mid();
        test_start_ignored();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
